// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - one master's request/response port into the data-memory arbiter
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       pc;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, pc, input ack, rdata);
  modport slave  (input req, we, lock, addr, wdata, pc, output ack, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master round-robin data-memory arbiter with bounded locked bursts
// Optional DM_ARB_TRACE_EN prints one line per committed write.
module dm_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam int CNT_W = 5;

  state_t           state, nextState;
  logic             last, nextLast;
  logic [CNT_W-1:0] beatCnt, nextBeatCnt;
  logic             ownIsM1, ownReq, ownLock, otherReq, beat, stay;

  // A beat only happens while owning with the owner requesting; reset suppresses it outright.
  always_comb begin
    ownIsM1  = (state == OWN1);
    ownReq   = ownIsM1 ? m1.req  : m0.req;
    ownLock  = ownIsM1 ? m1.lock : m0.lock;
    otherReq = ownIsM1 ? m0.req  : m1.req;
    beat     = (state != IDLE) && ownReq && !rst;
    stay     = ownReq && ownLock && (int'(beatCnt) + 1 < MAX_BURST);
  end

  always_comb begin
    nextState   = state;
    nextLast    = last;
    nextBeatCnt = beatCnt;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) nextState = last ? OWN0 : OWN1;
        else if (m0.req)      nextState = OWN0;
        else if (m1.req)      nextState = OWN1;
      end
      OWN0, OWN1: begin
        if (beat) nextBeatCnt = beatCnt + CNT_W'(1);
        if (!stay) begin
          nextLast  = ownIsM1;
          nextState = otherReq ? (ownIsM1 ? OWN0 : OWN1) : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (nextState != state && nextState != IDLE) nextBeatCnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      beatCnt <= '0;
    end else begin
      state   <= nextState;
      last    <= nextLast;
      beatCnt <= nextBeatCnt;
    end
  end

  always_comb begin
    m0.ack    = 1'b0;
    m1.ack    = 1'b0;
    m0.rdata  = '0;
    m1.rdata  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state == OWN0) begin
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_we    = beat && m0.we;
      m0.ack    = beat;
      m0.rdata  = beat ? mem_rdata : '0;
    end else if (state == OWN1) begin
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_we    = beat && m1.we;
      m1.ack    = beat;
      m1.rdata  = beat ? mem_rdata : '0;
    end
  end

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      if (state == OWN1) $display("@%h: *%h <= %h", m1.pc, m1.addr, m1.wdata);
      else               $display("@%h: *%h <= %h", m0.pc, m0.addr, m0.wdata);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^{m0.pc, m1.pc};
`endif
endmodule
